// File: rtl/load_store_unit.sv
// RV32I load/store unit: one data-memory transaction per accepted request, with byte-lane
// alignment on loads and lane replication on stores. Optional REQ timeout via LSU_BUS_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ls_valid_in,
  output logic        ls_ready_out,
  input  logic        ls_we_in,
  input  logic [2:0]  ls_funct3_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_be_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        store_done_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e state_q, state_d;

  logic [31:0] addr_q, wdata_q, load_data_q;
  logic [3:0]  be_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        load_valid_q, store_done_q, misaligned_q;

  logic        legal, aligned, accept, timeout;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] byte_sh, half_sh, load_ext;

  // Request decode: legality, alignment, lane enables and replicated store data
  always_comb begin
    legal      = 1'b0;
    aligned    = 1'b0;
    be_next    = 4'b1111;
    wdata_next = rs2_in;
    unique case (ls_funct3_in)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~ls_we_in;
      default:                legal = 1'b0;
    endcase
    case (ls_funct3_in[1:0])
      2'b00: begin
        aligned    = 1'b1;
        be_next    = 4'b0001 << iadder_in[1:0];
        wdata_next = {4{rs2_in[7:0]}};
      end
      2'b01: begin
        aligned    = ~iadder_in[0];
        be_next    = 4'b0011 << {iadder_in[1], 1'b0};
        wdata_next = {2{rs2_in[15:0]}};
      end
      2'b10: begin
        aligned    = (iadder_in[1:0] == 2'b00);
        be_next    = 4'b1111;
        wdata_next = rs2_in;
      end
      default: aligned = 1'b0;
    endcase
  end

  assign accept = ls_valid_in & ls_ready_out;

  // Load extraction from the captured address lane
  always_comb begin
    byte_sh  = dmem_rdata_in >> {addr_q[1:0], 3'b000};
    half_sh  = dmem_rdata_in >> {addr_q[1], 4'b0000};
    load_ext = dmem_rdata_in;
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100:  load_ext = {24'h0, byte_sh[7:0]};
      3'b101:  load_ext = {16'h0, half_sh[15:0]};
      default: load_ext = dmem_rdata_in;
    endcase
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;
  logic            bus_err_q;

  // Ack in the last counted cycle takes priority over the timeout
  assign timeout = (state_q == StReq) & ~dmem_ack_in &
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      cnt_q     <= (state_q == StReq && !timeout) ? cnt_q + 1'b1 : '0;
    end
  end

  assign bus_err_out = bus_err_q;
`else
  assign timeout     = 1'b0;
  assign bus_err_out = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && legal && aligned) state_d = StReq;
      StReq:  if (dmem_ack_in || timeout)     state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ls_ready_out = (state_q == StIdle);
    dmem_req_out = (state_q == StReq);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      misaligned_q <= accept & ~(legal & aligned);
      if (accept && legal && aligned) begin
        addr_q   <= iadder_in;
        wdata_q  <= wdata_next;
        be_q     <= be_next;
        funct3_q <= ls_funct3_in;
        we_q     <= ls_we_in;
      end
      if (state_q == StReq && dmem_ack_in) begin
        if (we_q) begin
          store_done_q <= 1'b1;
        end else begin
          load_valid_q <= 1'b1;
          load_data_q  <= load_ext;
        end
      end
    end
  end

  assign dmem_we_out    = we_q;
  assign dmem_addr_out  = {addr_q[31:2], 2'b00};
  assign dmem_wdata_out = wdata_q;
  assign dmem_be_out    = be_q;
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;
  assign store_done_out = store_done_q;
  assign misaligned_out = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses queued at drive time, popped when the
// response cycle is reached.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        ls_valid_in, ls_ready_out, ls_we_in;
  logic [2:0]  ls_funct3_in;
  logic [31:0] iadder_in, rs2_in;
  logic        dmem_req_out, dmem_we_out, dmem_ack_in;
  logic [31:0] dmem_addr_out, dmem_wdata_out, dmem_rdata_in, load_data_out;
  logic [3:0]  dmem_be_out;
  logic        load_valid_out, store_done_out, misaligned_out, bus_err_out;

  int checks = 0;
  int errors = 0;

  typedef enum int {KLoad, KStore, KMis, KErr} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] data;
  } item_t;
  item_t exp_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .ls_valid_in    (ls_valid_in),
    .ls_ready_out   (ls_ready_out),
    .ls_we_in       (ls_we_in),
    .ls_funct3_in   (ls_funct3_in),
    .iadder_in      (iadder_in),
    .rs2_in         (rs2_in),
    .dmem_req_out   (dmem_req_out),
    .dmem_we_out    (dmem_we_out),
    .dmem_addr_out  (dmem_addr_out),
    .dmem_wdata_out (dmem_wdata_out),
    .dmem_be_out    (dmem_be_out),
    .dmem_ack_in    (dmem_ack_in),
    .dmem_rdata_in  (dmem_rdata_in),
    .load_data_out  (load_data_out),
    .load_valid_out (load_valid_out),
    .store_done_out (store_done_out),
    .misaligned_out (misaligned_out),
    .bus_err_out    (bus_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in the cycle a response pulse is due
  task automatic check_resp(input string tag);
    item_t it;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed empty-queue expected response", tag);
      return;
    end
    it = exp_q.pop_front();
    chk({tag, ".load_valid"}, 32'(load_valid_out), 32'(it.kind == KLoad));
    chk({tag, ".store_done"}, 32'(store_done_out), 32'(it.kind == KStore));
    chk({tag, ".misaligned"}, 32'(misaligned_out), 32'(it.kind == KMis));
    chk({tag, ".bus_err"}, 32'(bus_err_out), 32'(it.kind == KErr));
    if (it.kind == KLoad) chk({tag, ".load_data"}, load_data_out, it.data);
  endtask

  // Entered just after a negedge; returns just after the negedge of the response cycle
  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] rs2, input int delay,
                      input logic [31:0] rdata, input logic [31:0] exp_addr,
                      input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                      input kind_e kind, input logic [31:0] exp_data);
    exp_q.push_back('{kind: kind, data: exp_data});
    ls_valid_in  = 1'b1;
    ls_we_in     = we;
    ls_funct3_in = f3;
    iadder_in    = addr;
    rs2_in       = rs2;
    @(posedge clk);
    @(negedge clk);
    ls_valid_in = 1'b0;
    if (kind == KMis) begin
      check_resp(tag);
      chk({tag, ".req"}, 32'(dmem_req_out), 32'd0);
      chk({tag, ".ready"}, 32'(ls_ready_out), 32'd1);
      return;
    end
    for (int i = 0; i <= delay; i++) begin
      chk({tag, ".req"}, 32'(dmem_req_out), 32'd1);
      chk({tag, ".ready"}, 32'(ls_ready_out), 32'd0);
      chk({tag, ".we"}, 32'(dmem_we_out), 32'(we));
      chk({tag, ".addr"}, dmem_addr_out, exp_addr);
      chk({tag, ".be"}, 32'(dmem_be_out), 32'(exp_be));
      if (we) chk({tag, ".wdata"}, dmem_wdata_out, exp_wdata);
      if (i == delay) begin
        dmem_ack_in   = 1'b1;
        dmem_rdata_in = rdata;
      end
      @(posedge clk);
      @(negedge clk);
    end
    dmem_ack_in = 1'b0;
    check_resp(tag);
  endtask

  initial begin
    rst_in        = 1'b1;
    ls_valid_in   = 1'b0;
    ls_we_in      = 1'b0;
    ls_funct3_in  = 3'b000;
    iadder_in     = '0;
    rs2_in        = '0;
    dmem_ack_in   = 1'b0;
    dmem_rdata_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_in = 1'b0;

    chk("rst.ready", 32'(ls_ready_out), 32'd1);
    chk("rst.req", 32'(dmem_req_out), 32'd0);
    chk("rst.be", 32'(dmem_be_out), 32'd0);
    chk("rst.load_data", load_data_out, 32'd0);
    chk("rst.pulses", 32'({load_valid_out, store_done_out, misaligned_out, bus_err_out}), 32'd0);

    xfer("lw", 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF,
         32'h100, 4'b1111, 32'h0, KLoad, 32'hDEADBEEF);
    xfer("lb", 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233,
         32'h100, 4'b1000, 32'h0, KLoad, 32'hFFFFFF80);
    xfer("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233,
         32'h100, 4'b1000, 32'h0, KLoad, 32'h00000080);
    xfer("sh", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'h0,
         32'h200, 4'b1100, 32'hABCDABCD, KStore, 32'h0);
    @(negedge clk);
    chk("sh.pulse_end", 32'(store_done_out), 32'd0);
    chk("sh.load_hold", load_data_out, 32'h00000080);
    xfer("lh", 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80112233,
         32'h100, 4'b1100, 32'h0, KLoad, 32'hFFFF8011);
    xfer("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 0, 32'h80119233,
         32'h100, 4'b0011, 32'h0, KLoad, 32'h00009233);
    xfer("sb", 1'b1, 3'b000, 32'h201, 32'h000000AB, 0, 32'h0,
         32'h200, 4'b0010, 32'hABABABAB, KStore, 32'h0);
    xfer("sw", 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 2, 32'h0,
         32'h300, 4'b1111, 32'hCAFEF00D, KStore, 32'h0);
    xfer("mis_lw", 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, KMis, 32'h0);
    xfer("mis_f011", 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, KMis, 32'h0);
    xfer("mis_sf100", 1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, KMis, 32'h0);
    xfer("mis_lh", 1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, KMis, 32'h0);
    @(negedge clk);
    chk("mis.pulse_end", 32'(misaligned_out), 32'd0);
    chk("mis.load_hold", load_data_out, 32'h00009233);

    // Reset during REQ abandons the transfer; a later ack in IDLE does nothing
    ls_valid_in  = 1'b1;
    ls_we_in     = 1'b0;
    ls_funct3_in = 3'b010;
    iadder_in    = 32'h100;
    @(posedge clk);
    @(negedge clk);
    ls_valid_in = 1'b0;
    chk("rstmid.req_before", 32'(dmem_req_out), 32'd1);
    rst_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    chk("rstmid.req", 32'(dmem_req_out), 32'd0);
    chk("rstmid.ready", 32'(ls_ready_out), 32'd1);
    chk("rstmid.load_data", load_data_out, 32'd0);
    dmem_ack_in   = 1'b1;
    dmem_rdata_in = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    dmem_ack_in = 1'b0;
    chk("rstmid.pulses", 32'({load_valid_out, store_done_out}), 32'd0);
    chk("rstmid.req_after", 32'(dmem_req_out), 32'd0);
    chk("rstmid.load_data_after", load_data_out, 32'd0);

`ifdef LSU_BUS_TIMEOUT_EN
    exp_q.push_back('{kind: KErr, data: 32'h0});
    ls_valid_in  = 1'b1;
    ls_we_in     = 1'b0;
    ls_funct3_in = 3'b010;
    iadder_in    = 32'h100;
    @(posedge clk);
    @(negedge clk);
    ls_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo.req", 32'(dmem_req_out), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    check_resp("tmo");
    chk("tmo.req_drop", 32'(dmem_req_out), 32'd0);
    chk("tmo.ready", 32'(ls_ready_out), 32'd1);
`endif

    @(negedge clk);
    chk("end.bus_err", 32'(bus_err_out), 32'd0);
    chk("end.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Consumer end of the address path: takes the effective address produced by the immediate adder (rs1 + imm) plus store data and funct3, and runs one data-memory transaction per accepted request.
- Load path: performs byte-lane alignment and sign/zero extension.
- Store path: generates byte enables and replicated write data.
- Sits between execute/decode and the data-memory port. Stalls the pipeline with a valid/ready handshake while a transfer is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, maximum REQ-state cycles before a bus error; used only with LSU_BUS_TIMEOUT_EN.

Ports:
clk_in  input  1  single clock, all logic on rising edge
rst_in  input  1  synchronous, active-high reset
ls_valid_in  input  1  load/store request valid
ls_ready_out  output  1  unit can accept a request (high only in IDLE)
ls_we_in  input  1  1 = store, 0 = load
ls_funct3_in  input  3  RV32I width/sign code
iadder_in  input  32  effective byte address from immediate adder
rs2_in  input  32  store data
dmem_req_out  output  1  memory request, held until ack
dmem_we_out  output  1  memory write enable
dmem_addr_out  output  32  word-aligned address {addr[31:2],2'b00}
dmem_wdata_out  output  32  lane-replicated store data
dmem_be_out  output  4  byte enables
dmem_ack_in  input  1  memory completion
dmem_rdata_in  input  32  memory read word
load_data_out  output  32  aligned, extended load result
load_valid_out  output  1  one-cycle pulse, load_data_out valid
store_done_out  output  1  one-cycle pulse on store ack
misaligned_out  output  1  one-cycle pulse, request rejected
bus_err_out  output  1  one-cycle pulse, timeout (feature only)

Behaviour:
- Reset (rst_in high at a clock edge):
  - State goes to IDLE.
  - ls_ready_out=1; all other outputs 0, including load_data_out=0 and dmem_be_out=0.
  - Reset mid-transfer abandons the transfer: dmem_req_out drops and no pulse is produced.
- States: IDLE, REQ.
- IDLE, ls_ready_out=1. Request accepted on ls_valid_in & ls_ready_out:
  - Legal funct3 values: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other code is treated as misaligned.
  - Misaligned accesses: halfword with addr[0]=1, or word with addr[1:0]!=0. Response: misaligned_out pulses next cycle, no bus request, state stays IDLE.
  - Otherwise: register addr, be, wdata, we and funct3, then go to REQ.
- REQ, ls_ready_out=0:
  - dmem_req_out=1, with addr/we/be/wdata stable until ack.
  - dmem_ack_in in the same cycle ends the transfer and returns to IDLE.
  - Load ack: capture and extend dmem_rdata_in into load_data_out, pulse load_valid_out next cycle. load_data_out holds until the next load.
  - Store ack: pulse store_done_out next cycle.
- Latency:
  - Request accepted at edge N; dmem_req_out high in cycle N+1.
  - Earliest ack is in cycle N+1, giving load_valid_out in cycle N+2.
  - A new request can be accepted in cycle N+2 (back-to-back throughput = 1 per 2 cycles minimum).
- Byte enables:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<{addr[1],1'b0}
  - SW: 4'b1111
  - Loads use the same pattern.
- Write data: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
- Load extraction:
  - Byte select = rdata >> (8*addr[1:0]); halfword select = rdata >> (16*addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- dmem_ack_in in IDLE is ignored. ls_valid_in while in REQ is ignored; the requester must hold it until ready.

Optional Feature:
LSU_BUS_TIMEOUT_EN:
- Defined: a counter runs in REQ. If TIMEOUT_CYCLES cycles pass without ack, dmem_req_out drops, bus_err_out pulses one cycle, state returns to IDLE, and no load_valid_out/store_done_out is produced. An ack in the final counted cycle wins over the timeout.
- Undefined: REQ waits indefinitely; bus_err_out is tied 0; no counter logic is present.

Test Plan:
- LW at addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> dmem_addr 0x100, be 4'b1111, load_data 0xDEADBEEF, load_valid_out 2 cycles after accept.
- LB at 0x103, rdata 0x80112233 -> be 4'b1000, load_data 0xFFFFFF80. LBU same -> 0x00000080.
- SH at 0x202, rs2 0x1234ABCD, ack after 3 wait cycles -> addr 0x200, be 4'b1100, wdata 0xABCDABCD held stable throughout, store_done_out one pulse.
- LW at 0x101 and funct3 011 -> misaligned_out pulse each, dmem_req_out never asserted, ready stays 1.
- rst_in asserted in REQ before ack -> next cycle dmem_req_out=0, ready=1, no valid/done pulse; a late ack is ignored.
- With LSU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err_out pulse after 4 REQ cycles, return to IDLE.
